// File: rtl/conv_pool_collector_if.sv
// conv_pool_collector_if: convolution result stream in, pooled result stream out.
interface conv_pool_collector_if #(parameter int DATA_W = 16);
    logic                     i_conv_valid;
    logic                     o_conv_ready;
    logic signed [DATA_W-1:0] i_conv_data;
    logic                     i_conv_row_start;
    logic                     i_conv_row_end;
    logic                     o_pool_valid;
    logic                     i_pool_ready;
    logic signed [DATA_W-1:0] o_pool_data;
    logic [3:0]               o_pool_row;
    logic [3:0]               o_pool_col;
    modport master (
        output i_conv_valid, i_conv_data, i_conv_row_start, i_conv_row_end, i_pool_ready,
        input  o_conv_ready, o_pool_valid, o_pool_data, o_pool_row, o_pool_col
    );
    modport slave (
        input  i_conv_valid, i_conv_data, i_conv_row_start, i_conv_row_end, i_pool_ready,
        output o_conv_ready, o_pool_valid, o_pool_data, o_pool_row, o_pool_col
    );
endinterface

// File: rtl/conv_pool_collector.sv
// conv_pool_collector: 2x2 stride-2 max pooling of a framed conv map into a one-entry output register.
// Define POOL_RELU_EN to clamp pooled outputs at zero.
module conv_pool_collector #(
    parameter int DATA_W = 16,
    parameter int IN_W   = 28,
    parameter int IN_H   = 28
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    output logic                  o_done,
    output logic                  o_row_err,
    conv_pool_collector_if.slave  bus
);
    localparam int CW = $clog2(IN_W);
    localparam int RW = $clog2(IN_H);
    localparam int BW = $clog2(IN_W / 2);
    typedef enum logic [2:0] {IDLE, EVEN, ODD, DRAIN, DONE} state_t;
    state_t                   state_q, state_d;
    logic [CW-1:0]            col_q, col_d, ecol;
    logic [RW-1:0]            row_q, row_d;
    logic signed [DATA_W-1:0] pair_q, pair_d;
    logic signed [DATA_W-1:0] rowbuf_q [IN_W/2];
    logic                     pv_q, pv_d, err_q, err_d;
    logic signed [DATA_W-1:0] pd_q, pd_d, m1, m2, mx;
    logic [3:0]               prow_q, prow_d, pcol_q, pcol_d;
    logic [BW-1:0]            idx;
    logic                     ready, active, restart, beat, at_end, last, load;
    always_comb begin
        ready   = (state_q == EVEN) || (state_q == ODD && (!pv_q || bus.i_pool_ready));
        active  = (state_q == EVEN) || (state_q == ODD);
        // a row_start mid-row throws away the partial row; this beat becomes col 0
        restart = active && bus.i_conv_row_start && col_q != '0;
        ecol    = restart ? '0 : col_q;
        idx     = ecol[CW-1:1];
        beat    = bus.i_conv_valid && ready;
        at_end  = ecol == CW'(IN_W - 1);
        last    = beat && (at_end || bus.i_conv_row_end);
        load    = beat && state_q == ODD && ecol[0];
        m1      = pair_q > bus.i_conv_data ? pair_q : bus.i_conv_data;
        m2      = rowbuf_q[idx] > m1 ? rowbuf_q[idx] : m1;
`ifdef POOL_RELU_EN
        mx      = m2[DATA_W-1] ? '0 : m2;
`else
        mx      = m2;
`endif
        state_d = state_q;
        row_d   = row_q;
        col_d   = last ? '0 : beat ? ecol + CW'(1) : ecol;
        pair_d  = beat && !ecol[0] ? bus.i_conv_data : pair_q;
        err_d   = err_q | restart | (beat && (at_end != bus.i_conv_row_end));
        pv_d    = load ? 1'b1 : (pv_q && bus.i_pool_ready) ? 1'b0 : pv_q;
        pd_d    = load ? mx : pd_q;
        prow_d  = load ? 4'(row_q >> 1) : prow_q;
        pcol_d  = load ? 4'(idx) : pcol_q;
        case (state_q)
            IDLE: if (i_start) begin
                state_d = EVEN;
                row_d   = '0;
                col_d   = '0;
                err_d   = 1'b0;
            end
            EVEN: if (last) begin
                state_d = ODD;
                row_d   = row_q + RW'(1);
            end
            ODD: if (last) begin
                state_d = row_q == RW'(IN_H - 1) ? DRAIN : EVEN;
                row_d   = row_q == RW'(IN_H - 1) ? row_q : row_q + RW'(1);
            end
            DRAIN: state_d = (!pv_q || bus.i_pool_ready) ? DONE : DRAIN;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            pair_q  <= '0;
            err_q   <= 1'b0;
            pv_q    <= 1'b0;
            pd_q    <= '0;
            prow_q  <= '0;
            pcol_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pair_q  <= pair_d;
            err_q   <= err_d;
            pv_q    <= pv_d;
            pd_q    <= pd_d;
            prow_q  <= prow_d;
            pcol_q  <= pcol_d;
        end
    end
    always_ff @(posedge clk)
        if (beat && state_q == EVEN && ecol[0])
            rowbuf_q[idx] <= m1;
    assign bus.o_conv_ready = ready;
    assign bus.o_pool_valid = pv_q;
    assign bus.o_pool_data  = pd_q;
    assign bus.o_pool_row   = prow_q;
    assign bus.o_pool_col   = pcol_q;
    assign o_done           = state_q == DONE;
    assign o_row_err        = err_q;
endmodule

// File: tb/tb_conv_pool_collector.sv
// tb_conv_pool_collector: scoreboard bench for the 28x28 -> 14x14 max-pool collector.
module tb_conv_pool_collector;
    logic clk = 0, reset = 1, i_start = 0;
    logic o_done, o_row_err;
    int   pass_cnt = 0, chk_cnt = 0, cyc = 0, last_hs = 0, n_out = 0;
    int   cur_row = -1, cur_col = -1;
    typedef struct {
        logic signed [15:0] d;
        logic [3:0]         r;
        logic [3:0]         c;
    } exp_t;
    exp_t q[$];
    conv_pool_collector_if #(.DATA_W(16)) bus ();
    conv_pool_collector #(.DATA_W(16), .IN_W(28), .IN_H(28)) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .o_done(o_done), .o_row_err(o_row_err), .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (!reset && bus.o_pool_valid && bus.i_pool_ready) begin
            exp_t e;
            chk_cnt++;
            last_hs = cyc;
            n_out++;
            if (q.size() == 0) begin
                $display("FAIL pool_out: unexpected output d=%0d r=%0d c=%0d", bus.o_pool_data, bus.o_pool_row, bus.o_pool_col);
            end else begin
                e = q.pop_front();
                if (bus.o_pool_data !== e.d || bus.o_pool_row !== e.r || bus.o_pool_col !== e.c)
                    $display("FAIL pool_out: got d=%0d r=%0d c=%0d want d=%0d r=%0d c=%0d",
                             bus.o_pool_data, bus.o_pool_row, bus.o_pool_col, e.d, e.r, e.c);
                else pass_cnt++;
            end
        end
    end
    function automatic logic signed [15:0] pix(input int mode, input int r, input int c);
        int k;
        k = (r / 2) * 14 + (c / 2);
        if (mode == 0) return 16'(r * 28 + c);
        return ((r % 2) * 2 + (c % 2)) == k % 4 ? -16'sd1 : -16'sd5;
    endfunction
    function automatic logic signed [15:0] exp_val(input int mode, input int pr, input int pc);
        if (mode == 0) return 16'((2 * pr + 1) * 28 + 2 * pc + 1);
`ifdef POOL_RELU_EN
        return 16'sd0;
`else
        return -16'sd1;
`endif
    endfunction
    task automatic start_pulse();
        @(posedge clk); #1 i_start = 1;
        @(posedge clk); #1 i_start = 0;
    endtask
    task automatic send(input logic signed [15:0] d, input logic rs, input logic re, output bit ok);
        bus.i_conv_valid = 1; bus.i_conv_data = d; bus.i_conv_row_start = rs; bus.i_conv_row_end = re;
        ok = 0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (bus.o_conv_ready) ok = 1;
            @(posedge clk); #1;
        end
        bus.i_conv_row_start = 0; bus.i_conv_row_end = 0;
        if (!ok) begin
            chk_cnt++;
            $display("FAIL beat_timeout: no ready for 200 cycles, want ready");
        end
    endtask
    task automatic stream_map(input int mode, input int err_row, input int abort_row);
        bit ok, stop;
        stop = 0;
        for (int r = 0; r < 28 && !stop; r++)
            for (int c = 0; c < 28 && !stop; c++)
                if (!(r == err_row && c > 20)) begin
                    cur_row = r; cur_col = c;
                    send(pix(mode, r, c), c == 0, c == 27 || (r == err_row && c == 20), ok);
                    if (ok && r % 2 == 1 && c % 2 == 1)
                        q.push_back('{exp_val(mode, r / 2, c / 2), 4'(r / 2), 4'(c / 2)});
                    if (!ok || (r == abort_row && c == 10)) stop = 1;
                end
        bus.i_conv_valid = 0;
        cur_row = -1; cur_col = -1;
    endtask
    task automatic run_full(input int mode, input int err_row);
        bit found;
        int done_cyc;
        n_out = 0;
        start_pulse();
        chk_cnt++;
        if (o_row_err !== 1'b0) $display("FAIL err_clear_on_start: got %b want 0", o_row_err);
        else pass_cnt++;
        stream_map(mode, err_row, -1);
        found = 0; done_cyc = 0;
        for (int t = 0; t < 50 && !found; t++) begin
            @(negedge clk);
            if (o_done) begin found = 1; done_cyc = cyc; end
        end
        chk_cnt++;
        if (!found || done_cyc != last_hs + 1)
            $display("FAIL done_timing: got found=%0b cycle=%0d want cycle %0d", found, done_cyc, last_hs + 1);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (o_done !== 1'b0) $display("FAIL done_pulse: got %b one cycle later want 0", o_done);
        else pass_cnt++;
        chk_cnt++;
        if (n_out != 196 || q.size() != 0) $display("FAIL out_count: got %0d left %0d want 196 left 0", n_out, q.size());
        else pass_cnt++;
        chk_cnt++;
        if (o_row_err !== (err_row >= 0)) $display("FAIL row_err: got %b want %b", o_row_err, err_row >= 0);
        else pass_cnt++;
    endtask
    task automatic test_reset();
        #1;
        chk_cnt++;
        if ({bus.o_conv_ready, o_done, bus.o_pool_valid, bus.o_pool_data, bus.o_pool_row, bus.o_pool_col, o_row_err} !== '0)
            $display("FAIL reset_state: got rdy=%b done=%b pv=%b d=%0d r=%0d c=%0d err=%b want all 0",
                     bus.o_conv_ready, o_done, bus.o_pool_valid, bus.o_pool_data, bus.o_pool_row, bus.o_pool_col, o_row_err);
        else pass_cnt++;
        @(posedge clk); #1 reset = 0;
    endtask
    task automatic test_idle_beats();
        bit bad = 0;
        bus.i_conv_valid = 1; bus.i_conv_data = 16'sd77;
        repeat (5) begin
            @(negedge clk);
            bad |= bus.o_conv_ready | bus.o_pool_valid;
        end
        bus.i_conv_valid = 0;
        chk_cnt++;
        if (bad) $display("FAIL idle_beats: got ready/valid asserted in IDLE want 0");
        else pass_cnt++;
    endtask
    task automatic test_ramp();
        run_full(0, -1);
    endtask
    task automatic test_negatives();
        run_full(1, -1);
    endtask
    task automatic test_backpressure();
        fork
            run_full(0, -1);
            begin
                bit reached = 0, stall_bad = 0, hold_bad = 0, seen = 0;
                logic [23:0] snap = '0;
                for (int t = 0; t < 5000 && !reached; t++) begin
                    @(posedge clk);
                    if (cur_row == 3 && cur_col >= 9) reached = 1;
                end
                #1 bus.i_pool_ready = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (bus.o_pool_valid) begin
                        if (bus.o_conv_ready) stall_bad = 1;
                        if (seen && snap !== {bus.o_pool_data, bus.o_pool_row, bus.o_pool_col}) hold_bad = 1;
                        snap = {bus.o_pool_data, bus.o_pool_row, bus.o_pool_col};
                        seen = 1;
                    end
                end
                @(posedge clk); #1 bus.i_pool_ready = 1;
                chk_cnt++;
                if (!reached || !seen || stall_bad)
                    $display("FAIL bp_stall: got reached=%b valid_seen=%b ready_while_full=%b want 1 1 0", reached, seen, stall_bad);
                else pass_cnt++;
                chk_cnt++;
                if (hold_bad) $display("FAIL bp_hold: got output fields changing under stall want stable");
                else pass_cnt++;
            end
        join
    endtask
    task automatic test_row_err();
        run_full(0, 4);
        start_pulse();
        chk_cnt++;
        if (o_row_err !== 1'b0) $display("FAIL row_err_cleared: got %b want 0", o_row_err);
        else pass_cnt++;
        reset = 1; #1 reset = 0;
    endtask
    task automatic test_mid_reset();
        start_pulse();
        stream_map(0, -1, 7);
        reset = 1;
        #1;
        chk_cnt++;
        if ({bus.o_pool_valid, bus.o_conv_ready, o_done} !== 3'b000)
            $display("FAIL mid_reset: got pv=%b rdy=%b done=%b want 000", bus.o_pool_valid, bus.o_conv_ready, o_done);
        else pass_cnt++;
        q.delete();
        @(posedge clk); #1 reset = 0;
        run_full(0, -1);
    endtask
    initial begin
        bus.i_conv_valid = 0; bus.i_conv_data = 0; bus.i_conv_row_start = 0; bus.i_conv_row_end = 0; bus.i_pool_ready = 1;
        test_reset();
        test_idle_beats();
        test_ramp();
        test_negatives();
        test_backpressure();
        test_row_err();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
